// File: rtl/memory_stage_controller.sv
// Memory-stage access controller: embedded word RAM behind a wait-state FSM that
// reports completion (MFC), out-of-range addresses (ANA) and conflicting requests.
module memory_stage_controller #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  Clock,
  input  logic                  Reset_L,
  input  logic                  MEM_Read,
  input  logic                  MEM_Write,
  input  logic [31:0]           MEM_Address,
  input  logic [DATA_WIDTH-1:0] MEM_DataIn,
  output logic [DATA_WIDTH-1:0] MEM_DataOut,
  output logic                  MEM_MFC,
  output logic                  MEM_ANA_FLAG,
  output logic                  MEM_Error,
  output logic                  MEM_Busy
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_HOLD} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                    ana_pend_q, ana_pend_d;
  logic                    mfc_q, mfc_d;
  logic                    ana_q, ana_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    req_c, both_c, none_c, oor_c;
  logic                    acc_c, acc_wr_c, mem_we_c;
  logic [DEPTH_LOG2-1:0]   addr_idx_c, acc_idx_c;
  logic                    unused_c;

  assign req_c      = MEM_Read ^ MEM_Write;
  assign both_c     = MEM_Read & MEM_Write;
  assign none_c     = ~MEM_Read & ~MEM_Write;
  assign addr_idx_c = MEM_Address[DEPTH_LOG2+1:2];
  assign oor_c      = (MEM_Address >> (DEPTH_LOG2 + 2)) != '0;
  assign unused_c   = ^MEM_Address[1:0];

  // Next-state, access strobe and completion flags
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    idx_d      = idx_q;
    ana_pend_d = ana_pend_q;
    acc_c      = 1'b0;
    acc_wr_c   = wr_q;
    acc_idx_c  = idx_q;
    mfc_d      = (state_q == ST_DONE);
    ana_d      = (state_q == ST_DONE) & ana_pend_q;
    err_d      = 1'b0;
    MEM_Busy   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        acc_wr_c  = MEM_Write;
        acc_idx_c = addr_idx_c;
        if (both_c) begin
          err_d   = 1'b1;
          state_d = ST_HOLD;
        end else if (req_c) begin
          MEM_Busy   = 1'b1;
          wr_d       = MEM_Write;
          idx_d      = addr_idx_c;
          cnt_d      = '0;
          ana_pend_d = oor_c;
          if (oor_c) begin
            state_d = ST_DONE;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_DONE;
            acc_c   = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        MEM_Busy = 1'b1;
        if (none_c) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(WAIT_STATES - 1)) begin
          state_d = ST_DONE;
          acc_c   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_HOLD;
      ST_HOLD: if (none_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM port: a reset on the access edge suppresses the store
  assign mem_we_c = acc_c & acc_wr_c & Reset_L;

  always_comb begin
    dout_d = dout_q;
    if (acc_c && !acc_wr_c) dout_d = mem[acc_idx_c];
  end

  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      ana_pend_q <= 1'b0;
      mfc_q      <= 1'b0;
      ana_q      <= 1'b0;
      err_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      ana_pend_q <= ana_pend_d;
      mfc_q      <= mfc_d;
      ana_q      <= ana_d;
      err_q      <= err_d;
      dout_q     <= dout_d;
    end
  end

  // Storage array is intentionally not reset
  always_ff @(posedge Clock) begin
    if (mem_we_c) mem[acc_idx_c] <= MEM_DataIn;
  end

  assign MEM_DataOut  = dout_q;
  assign MEM_MFC      = mfc_q;
  assign MEM_ANA_FLAG = ana_q;
  assign MEM_Error    = err_q;

endmodule
